// File: rtl/fifo_umbral_if.sv
// fifo_umbral_if
//   Bundles the handshake, threshold and status signals of one fifo_umbral
//   instance. Clock and reset stay outside the bundle as plain module ports.
//
//   master : the side that loads thresholds and issues push/pop requests
//            (flow-control FSM or a testbench).
//   slave  : the FIFO itself.
//
//   Signals
//     load_th      load af_th/ae_th into the FIFO threshold registers
//     af_th        almost-full threshold (0 selects DEPTH)
//     ae_th        almost-empty threshold
//     push/data_in write request and write data
//     pop          read request
//     data_out     registered read data, qualified by valid_out
//     empty/full/almost_full/almost_empty  occupancy status
//     error        overflow/underflow indication
interface fifo_umbral_if #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 2
);
    logic                  load_th;
    logic [ADDR_WIDTH-1:0] af_th;
    logic [ADDR_WIDTH-1:0] ae_th;
    logic                  push;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  pop;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid_out;
    logic                  empty;
    logic                  full;
    logic                  almost_full;
    logic                  almost_empty;
    logic                  error;

    modport master (
        output load_th, af_th, ae_th, push, data_in, pop,
        input  data_out, valid_out, empty, full, almost_full, almost_empty, error
    );

    modport slave (
        input  load_th, af_th, ae_th, push, data_in, pop,
        output data_out, valid_out, empty, full, almost_full, almost_empty, error
    );
endinterface

// File: rtl/fifo_umbral.sv
// fifo_umbral
//   Synchronous FIFO with programmable almost-full / almost-empty thresholds.
//   Thresholds come from the flow-control FSM (latched by it during INIT);
//   the empty and error bits feed that FSM's aggregated status buses.
//
//   Ports
//     clk    rising-edge clock
//     reset  asynchronous, active-high reset
//     bus    fifo_umbral_if.slave: load_th, af_th, ae_th, push, data_in, pop
//            in; data_out, valid_out, empty, full, almost_full,
//            almost_empty, error out
//
//   Parameters
//     DATA_WIDTH  stored word width
//     ADDR_WIDTH  pointer width, DEPTH = 2**ADDR_WIDTH
//     AF_DEFAULT  almost-full threshold after reset (0 selects DEPTH)
//     AE_DEFAULT  almost-empty threshold after reset
//
//   Build option
//     FIFO_ERROR_STICKY_EN  when defined, error stays set until reset;
//                           otherwise it is a one-cycle pulse per rejection.
module fifo_umbral #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 2,
    parameter int AF_DEFAULT = 3,
    parameter int AE_DEFAULT = 1
) (
    input  logic          clk,
    input  logic          reset,
    fifo_umbral_if.slave  bus
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    // DEPTH expressed in the count width (count spans 0..DEPTH).
    localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic [DATA_WIDTH-1:0] data_out_r;
    logic                  valid_out_r;
    logic                  error_r;
    logic [ADDR_WIDTH-1:0] af_th_r;
    logic [ADDR_WIDTH-1:0] ae_th_r;

    logic                  empty_c;
    logic                  full_c;
    logic [ADDR_WIDTH:0]   af_eff;
    logic                  pop_acc;
    logic                  push_acc;
    logic                  reject;
    logic                  error_nxt;

    // Status is derived purely from registered count and thresholds.
    always_comb begin
        empty_c = (count == '0);
        full_c  = (count == DEPTH_C);
        // A zero almost-full threshold means "use DEPTH", so almost_full
        // then coincides with full.
        af_eff  = (af_th_r == '0) ? DEPTH_C : {1'b0, af_th_r};
    end

    // A pop frees a slot in the same cycle, so a push into a full FIFO is
    // still accepted when paired with a pop. There is no bypass for the
    // empty case: the pop is rejected and the pushed word is read later.
    always_comb begin
        pop_acc  = bus.pop && !empty_c;
        push_acc = bus.push && (!full_c || pop_acc);
        reject   = (bus.push && !push_acc) || (bus.pop && !pop_acc);
    end

    always_comb begin
`ifdef FIFO_ERROR_STICKY_EN
        error_nxt = error_r || reject;
`else
        error_nxt = reject;
`endif
    end

    // Storage array carries no reset; stale words are unreachable once the
    // pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem[wr_ptr] <= bus.data_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            data_out_r  <= '0;
            valid_out_r <= 1'b0;
            error_r     <= 1'b0;
            af_th_r     <= ADDR_WIDTH'(AF_DEFAULT);
            ae_th_r     <= ADDR_WIDTH'(AE_DEFAULT);
        end else begin
            if (bus.load_th) begin
                af_th_r <= bus.af_th;
                ae_th_r <= bus.ae_th;
            end

            if (push_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end

            if (pop_acc) begin
                data_out_r  <= mem[rd_ptr];
                rd_ptr      <= rd_ptr + 1'b1;
                valid_out_r <= 1'b1;
            end else begin
                valid_out_r <= 1'b0;
            end

            case ({push_acc, pop_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            error_r <= error_nxt;
        end
    end

    assign bus.data_out     = data_out_r;
    assign bus.valid_out    = valid_out_r;
    assign bus.empty        = empty_c;
    assign bus.full         = full_c;
    assign bus.almost_full  = (count >= af_eff);
    assign bus.almost_empty = (count <= {1'b0, ae_th_r});
    assign bus.error        = error_r;

endmodule

// File: tb/tb_fifo_umbral.sv
module tb_fifo_umbral;

    localparam int DW = 8;
    localparam int AW = 2;
    localparam int DEPTH = 4;

    logic clk;
    logic reset;

    fifo_umbral_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    fifo_umbral #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .AF_DEFAULT(3),
        .AE_DEFAULT(1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: stored words, expected outputs, thresholds, error.
    logic [DW-1:0] m_q[$];
    logic [DW-1:0] exp_q[$];
    int            m_af = 3;
    int            m_ae = 1;
    logic          m_err = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_flags(input string where);
        int cnt;
        int af_eff;
        cnt    = m_q.size();
        af_eff = (m_af == 0) ? DEPTH : m_af;
        chk({where, ".empty"},        bus.empty,        32'(cnt == 0));
        chk({where, ".full"},         bus.full,         32'(cnt == DEPTH));
        chk({where, ".almost_full"},  bus.almost_full,  32'(cnt >= af_eff));
        chk({where, ".almost_empty"}, bus.almost_empty, 32'(cnt <= m_ae));
    endtask

    task automatic model_reset();
        m_q.delete();
        exp_q.delete();
        m_af  = 3;
        m_ae  = 1;
        m_err = 1'b0;
    endtask

    // One clock cycle of stimulus; the model predicts acceptance from its
    // own occupancy, then outputs are checked 1 time unit after the edge.
    task automatic cycle(input string tag, input logic ps, input logic [DW-1:0] d,
                         input logic pp, input logic ld = 1'b0,
                         input logic [AW-1:0] af = '0, input logic [AW-1:0] ae = '0);
        logic pop_ok, push_ok, rej;
        pop_ok  = pp && (m_q.size() != 0);
        push_ok = ps && ((m_q.size() != DEPTH) || pop_ok);
        rej     = (ps && !push_ok) || (pp && !pop_ok);

        bus.push    = ps;
        bus.data_in = d;
        bus.pop     = pp;
        bus.load_th = ld;
        bus.af_th   = af;
        bus.ae_th   = ae;
        @(posedge clk);
        #1;
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        bus.load_th = 1'b0;

        if (pop_ok) exp_q.push_back(m_q.pop_front());
        if (push_ok) m_q.push_back(d);
        if (ld) begin
            m_af = int'(af);
            m_ae = int'(ae);
        end
`ifdef FIFO_ERROR_STICKY_EN
        m_err = m_err | rej;
`else
        m_err = rej;
`endif

        chk({tag, ".valid_out"}, bus.valid_out, 32'(pop_ok));
        if (bus.valid_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk({tag, ".unexpected_data"}, bus.data_out, 32'hFFFF_FFFF);
            end else begin
                chk({tag, ".data_out"}, bus.data_out, 32'(exp_q.pop_front()));
            end
        end
        chk({tag, ".error"}, bus.error, 32'(m_err));
        check_flags(tag);
    endtask

    initial begin
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        bus.load_th = 1'b0;
        bus.data_in = '0;
        bus.af_th   = '0;
        bus.ae_th   = '0;
        reset       = 1'b1;
        #12;
        chk("rst.valid_out", bus.valid_out, 0);
        chk("rst.error",     bus.error,     0);
        chk("rst.data_out",  bus.data_out,  0);
        check_flags("rst");
        @(negedge clk);
        reset = 1'b0;

        cycle("idle", 1'b0, 8'h00, 1'b0);

        // Fill and drain in order.
        cycle("fill0", 1'b1, 8'h11, 1'b0);
        cycle("fill1", 1'b1, 8'h22, 1'b0);
        cycle("fill2", 1'b1, 8'h33, 1'b0);
        cycle("fill3", 1'b1, 8'h44, 1'b0);
        cycle("drain0", 1'b0, 8'h00, 1'b1);
        cycle("drain1", 1'b0, 8'h00, 1'b1);
        cycle("drain2", 1'b0, 8'h00, 1'b1);
        cycle("drain3", 1'b0, 8'h00, 1'b1);
        cycle("drained", 1'b0, 8'h00, 1'b0);

        // Overflow drops the word; underflow gives no valid data.
        for (int i = 0; i < 4; i++) cycle("refill", 1'b1, 8'(8'hA0 + i), 1'b0);
        cycle("ovf", 1'b1, 8'h3F, 1'b0);
        cycle("ovf_after", 1'b0, 8'h00, 1'b0);

        // Push and pop together on a full FIFO.
        cycle("full_pp", 1'b1, 8'h05, 1'b1);
        for (int i = 0; i < 4; i++) cycle("drain_pp", 1'b0, 8'h00, 1'b1);
        cycle("udf", 1'b0, 8'h00, 1'b1);
        cycle("udf_after", 1'b0, 8'h00, 1'b0);

        // Push and pop together on an empty FIFO: pop rejected.
        cycle("empty_pp", 1'b1, 8'h2A, 1'b1);
        cycle("empty_pp_rd", 1'b0, 8'h00, 1'b1);

        // Threshold loads.
        cycle("ld_2_0", 1'b0, 8'h00, 1'b0, 1'b1, 2'd2, 2'd0);
        for (int i = 0; i < 3; i++) cycle("th_fill", 1'b1, 8'(8'h50 + i), 1'b0);
        for (int i = 0; i < 3; i++) cycle("th_drain", 1'b0, 8'h00, 1'b1);
        cycle("ld_0_1", 1'b1, 8'h61, 1'b0, 1'b1, 2'd0, 2'd1);
        for (int i = 0; i < 3; i++) cycle("af0_fill", 1'b1, 8'(8'h62 + i), 1'b0);
        for (int i = 0; i < 4; i++) cycle("af0_drain", 1'b0, 8'h00, 1'b1);

        // Wrap-around with interleaved traffic.
        cycle("wrap_first", 1'b1, 8'($urandom_range(0, 255)), 1'b0);
        for (int i = 0; i < 10; i++)
            cycle("wrap", 1'b1, 8'($urandom_range(0, 255)), 1'b1);
        cycle("wrap_last", 1'b0, 8'h00, 1'b1);

        // Asynchronous reset in the middle of a burst.
        cycle("burst0", 1'b1, 8'h71, 1'b0);
        cycle("burst1", 1'b1, 8'h72, 1'b0);
        cycle("burst2", 1'b1, 8'h73, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        chk("arst.valid_out", bus.valid_out, 0);
        chk("arst.error",     bus.error,     0);
        check_flags("arst");
        @(negedge clk);
        reset = 1'b0;
        cycle("arst_idle", 1'b0, 8'h00, 1'b1);

        // One overflow, then idle: pulse by default, held when sticky.
        for (int i = 0; i < 4; i++) cycle("st_fill", 1'b1, 8'(8'h80 + i), 1'b0);
        cycle("st_ovf", 1'b1, 8'hFF, 1'b0);
        cycle("st_idle0", 1'b0, 8'h00, 1'b0);
        cycle("st_pop", 1'b0, 8'h00, 1'b1);
        cycle("st_idle1", 1'b0, 8'h00, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        chk("st_rst.error", bus.error, 0);
        @(negedge clk);
        reset = 1'b0;
        cycle("final_idle", 1'b0, 8'h00, 1'b0);

        chk("scoreboard_empty", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
